// File: rtl/landing_lights.sv
// Runway landing-light controller: free-running 32-bit clock divider plus a
// Moore FSM whose state code is driven straight onto the three lamps.
module landing_lights #(
    parameter int unsigned SIM_MODE    = 1,
    parameter int unsigned WHICH_CLOCK = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  w,
    output logic [2:0]  out,
    output logic [31:0] divided_clocks
);

    // Lamp patterns double as state codes; out[2] is the leftmost lamp.
    typedef enum logic [2:0] {
        CALM_OUT = 3'b101,
        MID      = 3'b010,
        LEFT     = 3'b100,
        RIGHT    = 3'b001
    } state_e;

    // Bits strictly below WHICH_CLOCK, and that field including WHICH_CLOCK.
    localparam logic [31:0] LOW_MASK   = (32'd1 << WHICH_CLOCK) - 32'd1;
    localparam logic [31:0] FIELD_MASK = (LOW_MASK << 1) | 32'd1;

    state_e      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic        step;

    // Divider increments every edge; wrap-around falls out of the 32-bit add.
    always_comb begin
        div_d = div_q + 32'd1;
    end

    // Step fires the cycle before divided_clocks[WHICH_CLOCK] rises:
    // that bit is 0 and every bit below it is 1.
    always_comb begin
        step = 1'b1;
        if (SIM_MODE == 0) begin
            step = ((div_q & FIELD_MASK) == LOW_MASK);
        end
    end

    // Next-state table; step acts purely as an enable, out holds otherwise.
    always_comb begin
        state_d = state_q;
        if (step) begin
            unique case (w)
                2'b01: begin
                    case (state_q)
                        RIGHT:    state_d = MID;
                        MID:      state_d = LEFT;
                        LEFT:     state_d = RIGHT;
                        CALM_OUT: state_d = MID;
                        default:  state_d = CALM_OUT;
                    endcase
                end
                2'b10: begin
                    case (state_q)
                        LEFT:     state_d = MID;
                        MID:      state_d = RIGHT;
                        RIGHT:    state_d = LEFT;
                        CALM_OUT: state_d = MID;
                        default:  state_d = CALM_OUT;
                    endcase
                end
                default: begin
                    case (state_q)
                        MID:      state_d = CALM_OUT;
                        CALM_OUT,
                        LEFT,
                        RIGHT:    state_d = MID;
                        default:  state_d = CALM_OUT;
                    endcase
                end
            endcase
        end
    end

    // State and divider registers; reset overrides step and w.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CALM_OUT;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    assign out            = state_q;
    assign divided_clocks = div_q;

endmodule

// File: tb/tb_landing_lights.sv
// Scoreboard bench for landing_lights: one instance at simulation rate and
// one at board rate (WHICH_CLOCK=2), sharing a clock.
module tb_landing_lights;

    logic        clk = 1'b0;
    logic        rst_s, rst_b;
    logic [1:0]  w_s, w_b;
    logic [2:0]  out_s, out_b;
    logic [31:0] dc_s, dc_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          sel;  // 0 sim out, 1 sim counter, 2 board out, 3 board counter
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    landing_lights #(.SIM_MODE(1), .WHICH_CLOCK(24)) u_sim (
        .clk(clk), .reset(rst_s), .w(w_s), .out(out_s), .divided_clocks(dc_s)
    );

    landing_lights #(.SIM_MODE(0), .WHICH_CLOCK(2)) u_brd (
        .clk(clk), .reset(rst_b), .w(w_b), .out(out_b), .divided_clocks(dc_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Advance one edge, then drain the scoreboard against DUT outputs.
    task automatic tick();
        exp_t e;
        logic [31:0] act;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       act = {29'd0, out_s};
                1:       act = dc_s;
                2:       act = {29'd0, out_b};
                default: act = dc_b;
            endcase
            check_val(e.tag, act, e.exp);
        end
    endtask

    // Independent reference for the lamp sequence.
    function automatic logic [2:0] ref_next(input logic [2:0] cur, input logic [1:0] wv);
        if (cur != 3'b101 && cur != 3'b010 && cur != 3'b100 && cur != 3'b001) return 3'b101;
        if (cur == 3'b101) return 3'b010;
        if (wv == 2'b01) return (cur == 3'b001) ? 3'b010 : (cur == 3'b010) ? 3'b100 : 3'b001;
        if (wv == 2'b10) return (cur == 3'b100) ? 3'b010 : (cur == 3'b010) ? 3'b001 : 3'b100;
        return (cur == 3'b010) ? 3'b101 : 3'b010;
    endfunction

    task automatic sim_step(input string tag, input logic [1:0] wv, input logic [2:0] exp);
        w_s = wv;
        expect_val(tag, 0, {29'd0, exp});
        tick();
    endtask

    logic [2:0]  model;
    logic [1:0]  wr;
    logic [2:0]  cal_seq [4] = '{3'b010, 3'b101, 3'b010, 3'b101};
    logic [2:0]  r2l_seq [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    logic [2:0]  l2r_seq [4] = '{3'b001, 3'b100, 3'b010, 3'b001};
    int          steps;

    initial begin
        rst_s = 1'b1; rst_b = 1'b1; w_s = 2'b00; w_b = 2'b00;
        @(negedge clk);

        // Reset state
        expect_val("rst_out", 0, 32'h5);
        expect_val("rst_dc", 1, 32'h0);
        tick();
        rst_s = 1'b0;
        sim_step("rel_e1", 2'b00, 3'b010);
        sim_step("rel_e2", 2'b00, 3'b101);
        expect_val("rel_dc3", 1, 32'd3);
        sim_step("rel_e3", 2'b00, 3'b010);

        // Calm
        rst_s = 1'b1;
        expect_val("rst2_out", 0, 32'h5);
        tick();
        rst_s = 1'b0;
        for (int i = 0; i < 4; i++) sim_step("calm", 2'b00, cal_seq[i]);

        // Right-to-left from 101
        for (int i = 0; i < 4; i++) sim_step("r2l", 2'b01, r2l_seq[i]);

        // Left-to-right from 010, then 11 treated as calm
        for (int i = 0; i < 4; i++) sim_step("l2r", 2'b10, l2r_seq[i]);
        sim_step("w11_a", 2'b11, 3'b010);
        sim_step("w11_b", 2'b11, 3'b101);

        // Mid-run reset at 100
        sim_step("pre_a", 2'b01, 3'b010);
        sim_step("pre_b", 2'b01, 3'b100);
        rst_s = 1'b1;
        expect_val("mid_rst_dc", 1, 32'h0);
        sim_step("mid_rst", 2'b01, 3'b101);
        rst_s = 1'b0;
        sim_step("post_rst", 2'b01, 3'b010);

        // Random wind against the reference
        model = 3'b010;
        for (int i = 0; i < 40; i++) begin
            wr = 2'($urandom_range(0, 3));
            model = ref_next(model, wr);
            sim_step("rand", wr, model);
        end

        // Board rate: step on edges 4, 12, 20, ... after release
        rst_b = 1'b1;
        w_b = 2'b00;
        expect_val("brd_rst_out", 2, 32'h5);
        expect_val("brd_rst_dc", 3, 32'h0);
        tick();
        rst_b = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            steps = (n >= 4) ? ((n - 4) / 8 + 1) : 0;
            expect_val("brd_out", 2, (steps % 2 == 0) ? 32'h5 : 32'h2);
            expect_val("brd_dc", 3, n);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
